// File: rtl/tnoc_output_port_scheduler.sv
// Per-output-port packet scheduler.
// Each virtual channel owns an independent round-robin arbiter that locks the
// output to one input entry from a winning head flit until that entry's tail
// flit is accepted. Grants and busy flags are flop outputs.

package tnoc_pkg;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned tags;
        int unsigned data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        tags:             256,
        data_width:       256
    };

endpackage

module tnoc_output_port_scheduler
    import tnoc_pkg::*;
#(
    parameter tnoc_config CONFIG   = TNOC_DEFAULT_CONFIG,
    parameter int         ENTRIES  = 5,
    localparam int        CHANNELS = int'(CONFIG.virtual_channels)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ENTRIES*CHANNELS-1:0] i_request,
    input  logic [ENTRIES*CHANNELS-1:0] i_start_of_packet,
    input  logic [ENTRIES*CHANNELS-1:0] i_end_of_packet,
    output logic [ENTRIES*CHANNELS-1:0] o_grant,
    output logic [CHANNELS-1:0]         o_busy
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic [PTR_W-1:0] ptr_t;

    // Modulo-ENTRIES addition; both operands are below ENTRIES, so a single
    // conditional subtraction is enough.
    function automatic ptr_t wrap_add(ptr_t base, int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= ENTRIES) begin
            sum = sum - ENTRIES;
        end
        return ptr_t'(sum);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        state_e             state_q;
        state_e             state_d;
        ptr_t               ptr_q;
        ptr_t               ptr_d;
        ptr_t               winner;
        logic               found;
        logic               owner_eop;
        // The one-hot grant register doubles as the owner index.
        logic [ENTRIES-1:0] grant_q;
        logic [ENTRIES-1:0] grant_d;
        logic [ENTRIES-1:0] candidates;
        logic [ENTRIES-1:0] tails;

        // Gather this VC's head-flit candidates and tail indications per entry.
        always_comb begin
            // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
            candidates = '0;
            tails      = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                candidates[e] = i_request[e*CHANNELS + c] & i_start_of_packet[e*CHANNELS + c];
                tails[e]      = i_end_of_packet[e*CHANNELS + c];
            end
            // An owner's head flit seen while it holds the grant belongs to the
            // packet already granted (single-flit case), so it never re-competes.
            candidates = candidates & ~grant_q;
        end

        // Round-robin search: first candidate at or after the pointer, wrapping.
        always_comb begin
            found  = 1'b0;
            winner = ptr_q;
            for (int i = 0; i < ENTRIES; i++) begin
                if (!found && candidates[wrap_add(ptr_q, i)]) begin
                    found  = 1'b1;
                    winner = wrap_add(ptr_q, i);
                end
            end
        end

        // Only the current owner's tail flit releases the lock.
        assign owner_eop = |(grant_q & tails);

        // Next-state logic: arbitrate when idle or when the owner finishes.
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            grant_d = grant_q;
            if ((state_q == IDLE) || owner_eop) begin
                grant_d = '0;
                if (found) begin
                    state_d         = BUSY;
                    grant_d[winner] = 1'b1;
                    ptr_d           = wrap_add(winner, 1);
                end else begin
                    state_d = IDLE;
                end
            end
        end

        // State, pointer and grant registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                grant_q <= '0;
            end else begin
                // NOTE: non-blocking assignments so every register samples the pre-edge values.
                state_q <= state_d;
                ptr_q   <= ptr_d;
                grant_q <= grant_d;
            end
        end

        assign o_busy[c] = (state_q == BUSY);

        for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
            assign o_grant[e*CHANNELS + c] = grant_q[e];
        end
    end

endmodule

// File: doc/tnoc_output_port_scheduler.md
# tnoc_output_port_scheduler

Per-output-port packet scheduler for the router. It receives, from every input port's route selector, the per-virtual-channel `request`, `start_of_packet` and `end_of_packet` indications targeting this output port. Independently for each virtual channel, it grants the output to one input port by round-robin and holds that grant for the whole packet. The grant vector drives the output port's VC merger and feeds back to the input ports.

## Interface
- `CONFIG`, default `TNOC_DEFAULT_CONFIG`: NoC configuration; `CHANNELS = CONFIG.virtual_channels` (localparam).
- `ENTRIES`, default 5: number of input ports competing for this output port.
- Flattened vector index for all per-entry/per-VC signals below: `e*CHANNELS + c`, where e = entry and c = VC.
- `clk`, input, 1: clock; sole clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_request`, input, ENTRIES*CHANNELS: flit valid from entry e on VC c routed to this port.
- `i_start_of_packet`, input, ENTRIES*CHANNELS: head flit valid on entry e / VC c.
- `i_end_of_packet`, input, ENTRIES*CHANNELS: tail flit accepted (valid & ready) on entry e / VC c.
- `o_grant`, output, ENTRIES*CHANNELS: registered; entry e owns VC c of this output port.
- `o_busy`, output, CHANNELS: registered; VC c is locked to some entry (OR of its grant bits).

## Operation
- Each VC c has an independent scheduler: state IDLE/BUSY, owner index, and round-robin pointer `ptr[c]` (range 0..ENTRIES-1).
- Candidates for VC c: entries with `i_request & i_start_of_packet` set at index e*CHANNELS+c.
- Selection: first candidate in the order ptr, ptr+1, …, ENTRIES-1, 0, …, ptr-1 (modulo ENTRIES).
- IDLE with ≥1 candidate: register the grant to winner w, go to BUSY, set owner = w, and set `ptr[c]` = (w+1) mod ENTRIES.
- IDLE with no candidate: stay IDLE; `o_grant` for VC c is all zero.
- BUSY: hold the grant unchanged regardless of `i_request` (gaps inside a packet keep the lock).
- BUSY, `i_end_of_packet` at owner index:
  - If another candidate exists in the same cycle, arbitrate with the already-updated ptr. The new winner is granted next cycle and the state stays BUSY (back-to-back, no idle gap).
  - Otherwise go to IDLE and drop the grant next cycle.
- Single-flit packets: SOP wins arbitration. The flit is then accepted under the grant, and SOP and EOP coincide that cycle; EOP handling is as above.
- EOP from a non-owner entry: ignored. SOP from a non-winner: ignored this cycle; the request stays pending and the input holds the flit.
- Per VC, at most one `o_grant` bit is set. One entry may hold grants on several VCs at once.
- VCs never interact: arbitration on c is independent of c'.

## Timing
- Reset (async assert): all `o_grant`=0, all `o_busy`=0, all states IDLE, all `ptr`=0 (entry 0 highest priority).
- Reset release: first arbitration on the first clock edge with `rst_n`=1.
- Grant latency: SOP sampled at edge N → `o_grant` high from edge N (visible cycle N+1).
- Release latency: EOP sampled at edge M → grant low, or next winner's grant high, from edge M.
- Grants never change except on an owner EOP (BUSY) or a winning SOP (IDLE).
- Reset mid-packet: grants cleared immediately, ptr returns to 0, partial packet ownership is lost.
- All outputs are flop outputs; no combinational input-to-output path.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `o_grant`=0, `o_busy`=0; release with SOP on entry 3 VC0 → grant bit 3*CHANNELS+0 high next cycle, `ptr[0]`=4.
- Round-robin: ENTRIES=5, CHANNELS=2; entries 0,2,4 hold SOP on VC1 continuously with 3-flit packets → grant order on VC1 is 0,2,4,0,… with no idle cycle between packets.
- Packet lock: entry 1 granted VC0; entry 1 `i_request` drops for 4 cycles mid-packet while entry 3 asserts SOP → grant stays on entry 1 until its EOP, then entry 3 is granted the next cycle.
- Single-flit packets: entries 0 and 1 send SOP+EOP packets on VC0 → grants alternate 0,1,0,1, one packet per grant.
- VC independence: entry 2 holds a long packet on VC0 while entries 2 and 4 send on VC1 → VC1 arbitrates normally; entry 2 may hold VC0 and VC1 grants simultaneously; `o_busy`=2'b11.
- Spurious EOP and mid-packet reset: EOP from a non-owner → no grant change; `rst_n` low during a BUSY packet → `o_grant`=0 asynchronously and `ptr` returns to 0.
